uart_port: RTL and testbench

Byte-wide I/O responder for a PC-compatible serial port (8250/16450 register model, 8N1 only) with 16-entry RX and TX FIFOs. Sits behind the 16-to-8 bit I/O bridge and is the responder end of the toggle request/acknowledge handshake that the bridge drives for SPI, PIT, PIC and VGA. Drives `uart_txd`, samples `uart_rxd` and raises a level IRQ toward PIC input 4 (COM1, decoded at I/O 3F8–3FF by the bridge).

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_fifo.sv | 64 ++++++
 rtl/uart_port.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_uart_port.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the 8250-style serial port: register offsets,
// interrupt identification codes, line status bit positions and FSM states.
package uart_pkg;

   localparam logic [2:0] REG_RBR_THR = 3'd0;
   localparam logic [2:0] REG_IER     = 3'd1;
   localparam logic [2:0] REG_IIR     = 3'd2;
   localparam logic [2:0] REG_LCR     = 3'd3;
   localparam logic [2:0] REG_MCR     = 3'd4;
   localparam logic [2:0] REG_LSR     = 3'd5;
   localparam logic [2:0] REG_MSR     = 3'd6;
   localparam logic [2:0] REG_SCR     = 3'd7;

   localparam logic [7:0] IIR_LINE   = 8'h06;
   localparam logic [7:0] IIR_RXDATA = 8'h04;
   localparam logic [7:0] IIR_THRE   = 8'h02;
   localparam logic [7:0] IIR_NONE   = 8'h01;

   localparam int LSR_DR   = 0;
   localparam int LSR_OE   = 1;
   localparam int LSR_FE   = 3;
   localparam int LSR_THRE = 5;
   localparam int LSR_TEMT = 6;

   localparam logic [15:0] DIV_RESET = 16'd12;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // A programmed divisor of zero behaves like one.
   function automatic logic [15:0] div_eff(input logic [15:0] div);
      return (div == 16'd0) ? 16'd1 : div;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted only when a pop
// happens in the same cycle, otherwise it is dropped.
module uart_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   // Qualify push/pop against occupancy and advance pointers and count.
   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != FULL_CNT) || do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (!do_push && do_pop) begin
         count_d = count_q - 1'b1;
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset since occupancy guards reads.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/uart_port.sv
// 8250/16450-compatible serial port (8N1) behind the toggle handshake of the
// I/O bridge. Baud generator, transmitter, receiver and register file.
//
// state    | meaning
// TX_IDLE  | line high, pops the TX FIFO when it holds a byte
// TX_START | start bit (low) for 16 x16 ticks
// TX_DATA  | 8 data bits LSB first, 16 ticks each
// TX_STOP  | stop bit (high); chains straight into the next byte if queued
// RX_IDLE  | waiting for the line to go low
// RX_START | counts 8 ticks to mid start bit, high there is a false start
// RX_DATA  | samples 8 data bits every 16 ticks
// RX_STOP  | samples stop bit, pushes the byte, flags framing/overrun
module uart_port
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int REF_HZ     = 1_843_200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [23:0] port,
   input  logic [7:0]  din,
   output logic [7:0]  dout,
   input  logic        cpu_iordin,
   output logic        cpu_iordout,
   input  logic        cpu_iowrin,
   output logic        cpu_iowrout,
   output logic        ready,
   output logic        irq,
   input  logic        rxd,
   output logic        txd
);
   localparam int          CW    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [32:0] CLK_W = 33'(CLK_HZ);
   localparam logic [32:0] REF_W = 33'(REF_HZ);

   logic [31:0] acc_q, acc_d;
   logic [32:0] acc_sum;
   logic        ref_tick, tick16;
   logic [15:0] div_cnt_q, div_cnt_d;

   logic [7:0]  dll_q, dll_d, dlm_q, dlm_d, lcr_q, lcr_d, scr_q, scr_d;
   logic [2:0]  ier_q, ier_d;
   logic [4:0]  mcr_q, mcr_d;
   logic [7:0]  dout_q, dout_d, rbr_last_q, rbr_last_d, rd_data, iir, lsr;
   logic        rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d;
   logic        oe_q, oe_d, fe_q, fe_d, thre_q, thre_d;
   logic        tx_empty_prev_q, tx_empty_prev_d, irq_q, irq_d;

   logic        wr_pend, rd_pend, do_wr, do_rd, dlab;
   logic [2:0]  addr;
   logic        wr_thr, wr_dll, wr_dlm, wr_ier, rd_rbr, rd_iir, rd_lsr;

   logic [7:0]  rx_head, tx_head;
   logic        rx_full, rx_empty, tx_full, tx_empty, rx_pop, tx_pop;
   logic [CW-1:0] rx_count, tx_count;

   tx_state_t   tx_state_q, tx_state_d;
   logic [3:0]  tx_cnt_q, tx_cnt_d;
   logic [2:0]  tx_bits_q, tx_bits_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic        tx_ser;

   rx_state_t   rx_state_q, rx_state_d;
   logic [3:0]  rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bits_q, rx_bits_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic [1:0]  rx_sync_q, rx_sync_d;
   logic        rx_in, rx_done, rx_stop_bad;

   logic        unused_sigs;
   assign unused_sigs = ^{port[23:3], rx_count, tx_count, tx_full};

   // Bus decode: a write request is served before a read request.
   always_comb begin
      wr_pend = (cpu_iowrin != wr_ack_q);
      rd_pend = (cpu_iordin != rd_ack_q);
      do_wr   = wr_pend;
      do_rd   = rd_pend && !wr_pend;
      addr    = port[2:0];
      dlab    = lcr_q[7];
      wr_thr  = do_wr && (addr == REG_RBR_THR) && !dlab;
      wr_dll  = do_wr && (addr == REG_RBR_THR) && dlab;
      wr_dlm  = do_wr && (addr == REG_IER) && dlab;
      wr_ier  = do_wr && (addr == REG_IER) && !dlab;
      rd_rbr  = do_rd && (addr == REG_RBR_THR) && !dlab;
      rd_iir  = do_rd && (addr == REG_IIR);
      rd_lsr  = do_rd && (addr == REG_LSR);
   end

   // Writable register file and write acknowledge.
   always_comb begin
      dll_d    = dll_q;
      dlm_d    = dlm_q;
      ier_d    = ier_q;
      lcr_d    = lcr_q;
      mcr_d    = mcr_q;
      scr_d    = scr_q;
      wr_ack_d = wr_ack_q;
      if (do_wr) begin
         wr_ack_d = cpu_iowrin;
         case (addr)
            REG_RBR_THR: if (dlab) dll_d = din;
            REG_IER:     if (dlab) dlm_d = din; else ier_d = din[2:0];
            REG_LCR:     lcr_d = din;
            REG_MCR:     mcr_d = din[4:0];
            REG_SCR:     scr_d = din;
            default:     ;
         endcase
      end
   end

   // Status views seen by the host.
   always_comb begin
      lsr           = 8'h00;
      lsr[LSR_DR]   = !rx_empty;
      lsr[LSR_OE]   = oe_q;
      lsr[LSR_FE]   = fe_q;
      lsr[LSR_THRE] = tx_empty;
      lsr[LSR_TEMT] = tx_empty && (tx_state_q == TX_IDLE);
      if (ier_q[2] && (oe_q || fe_q)) begin
         iir = IIR_LINE;
      end else if (ier_q[0] && !rx_empty) begin
         iir = IIR_RXDATA;
      end else if (ier_q[1] && thre_q) begin
         iir = IIR_THRE;
      end else begin
         iir = IIR_NONE;
      end
   end

   // Read data mux, read acknowledge and RBR hold value.
   always_comb begin
      case (addr)
         REG_RBR_THR: rd_data = dlab ? dll_q : (rx_empty ? rbr_last_q : rx_head);
         REG_IER:     rd_data = dlab ? dlm_q : {5'b0, ier_q};
         REG_IIR:     rd_data = iir;
         REG_LCR:     rd_data = lcr_q;
         REG_MCR:     rd_data = {3'b0, mcr_q};
         REG_LSR:     rd_data = lsr;
         REG_MSR:     rd_data = 8'h00;
         default:     rd_data = scr_q;
      endcase
      dout_d     = do_rd ? rd_data : dout_q;
      rd_ack_d   = do_rd ? cpu_iordin : rd_ack_q;
      rx_pop     = rd_rbr;
      rbr_last_d = (rd_rbr && !rx_empty) ? rx_head : rbr_last_q;
   end

   // Error flags, THRE interrupt arming and registered irq.
   always_comb begin
      oe_d = oe_q;
      fe_d = fe_q;
      if (rd_lsr) begin
         oe_d = 1'b0;
         fe_d = 1'b0;
      end
      if (rx_done) begin
         if (rx_stop_bad) fe_d = 1'b1;
         if (rx_full && !rx_pop) oe_d = 1'b1;
      end
      tx_empty_prev_d = tx_empty;
      thre_d = thre_q;
      if (wr_thr || (rd_iir && (iir == IIR_THRE))) thre_d = 1'b0;
      if ((tx_empty && !tx_empty_prev_q) || (wr_ier && din[1] && !ier_q[1])) thre_d = 1'b1;
      irq_d = !iir[0];
   end

   // Baud generation: fractional ref tick, then down-counted x16 tick.
   always_comb begin
      acc_sum  = {1'b0, acc_q} + REF_W;
      acc_d    = acc_sum[31:0];
      ref_tick = 1'b0;
      if (acc_sum >= CLK_W) begin
         acc_d    = 32'(acc_sum - CLK_W);
         ref_tick = 1'b1;
      end
      div_cnt_d = div_cnt_q;
      tick16    = 1'b0;
      if (wr_dll || wr_dlm) begin
         div_cnt_d = div_eff({dlm_d, dll_d});
      end else if (ref_tick) begin
         if (div_cnt_q <= 16'd1) begin
            tick16    = 1'b1;
            div_cnt_d = div_eff({dlm_q, dll_q});
         end else begin
            div_cnt_d = div_cnt_q - 16'd1;
         end
      end
   end

   // Transmitter FSM.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bits_d  = tx_bits_q;
      tx_shift_d = tx_shift_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_head;
               tx_cnt_d   = 4'd15;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tick16) begin
               if (tx_cnt_q == 4'd0) begin
                  tx_state_d = TX_DATA;
                  tx_cnt_d   = 4'd15;
                  tx_bits_d  = 3'd7;
               end else begin
                  tx_cnt_d = tx_cnt_q - 4'd1;
               end
            end
         end
         TX_DATA: begin
            if (tick16) begin
               if (tx_cnt_q == 4'd0) begin
                  tx_cnt_d = 4'd15;
                  if (tx_bits_q == 3'd0) begin
                     tx_state_d = TX_STOP;
                  end else begin
                     tx_shift_d = {1'b0, tx_shift_q[7:1]};
                     tx_bits_d  = tx_bits_q - 3'd1;
                  end
               end else begin
                  tx_cnt_d = tx_cnt_q - 4'd1;
               end
            end
         end
         TX_STOP: begin
            if (tick16) begin
               if (tx_cnt_q == 4'd0) begin
                  if (!tx_empty) begin
                     tx_pop     = 1'b1;
                     tx_shift_d = tx_head;
                     tx_cnt_d   = 4'd15;
                     tx_state_d = TX_START;
                  end else begin
                     tx_state_d = TX_IDLE;
                  end
               end else begin
                  tx_cnt_d = tx_cnt_q - 4'd1;
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
      tx_ser = (tx_state_q == TX_START) ? 1'b0 :
               (tx_state_q == TX_DATA)  ? tx_shift_q[0] : 1'b1;
   end

   // Receiver FSM; loopback feeds the internal serial out straight in.
   always_comb begin
      rx_sync_d   = {rx_sync_q[0], rxd};
      rx_in       = mcr_q[4] ? tx_ser : rx_sync_q[1];
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q;
      rx_bits_d   = rx_bits_q;
      rx_shift_d  = rx_shift_q;
      rx_done     = 1'b0;
      rx_stop_bad = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (!rx_in) begin
               rx_state_d = RX_START;
               rx_cnt_d   = 4'd7;
            end
         end
         RX_START: begin
            if (tick16) begin
               if (rx_cnt_q == 4'd0) begin
                  rx_cnt_d   = 4'd15;
                  rx_bits_d  = 3'd7;
                  rx_state_d = rx_in ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_d = rx_cnt_q - 4'd1;
               end
            end
         end
         RX_DATA: begin
            if (tick16) begin
               if (rx_cnt_q == 4'd0) begin
                  rx_shift_d = {rx_in, rx_shift_q[7:1]};
                  rx_cnt_d   = 4'd15;
                  if (rx_bits_q == 3'd0) rx_state_d = RX_STOP;
                  else rx_bits_d = rx_bits_q - 3'd1;
               end else begin
                  rx_cnt_d = rx_cnt_q - 4'd1;
               end
            end
         end
         RX_STOP: begin
            if (tick16) begin
               if (rx_cnt_q == 4'd0) begin
                  rx_done     = 1'b1;
                  rx_stop_bad = !rx_in;
                  rx_state_d  = RX_IDLE;
               end else begin
                  rx_cnt_d = rx_cnt_q - 4'd1;
               end
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // All state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q           <= '0;
         div_cnt_q       <= DIV_RESET;
         dll_q           <= DIV_RESET[7:0];
         dlm_q           <= DIV_RESET[15:8];
         ier_q           <= '0;
         lcr_q           <= '0;
         mcr_q           <= '0;
         scr_q           <= '0;
         dout_q          <= '0;
         rbr_last_q      <= '0;
         rd_ack_q        <= 1'b0;
         wr_ack_q        <= 1'b0;
         oe_q            <= 1'b0;
         fe_q            <= 1'b0;
         thre_q          <= 1'b0;
         tx_empty_prev_q <= 1'b1;
         irq_q           <= 1'b0;
         tx_state_q      <= TX_IDLE;
         tx_cnt_q        <= '0;
         tx_bits_q       <= '0;
         tx_shift_q      <= '0;
         rx_state_q      <= RX_IDLE;
         rx_cnt_q        <= '0;
         rx_bits_q       <= '0;
         rx_shift_q      <= '0;
         rx_sync_q       <= 2'b11;
      end else begin
         acc_q           <= acc_d;
         div_cnt_q       <= div_cnt_d;
         dll_q           <= dll_d;
         dlm_q           <= dlm_d;
         ier_q           <= ier_d;
         lcr_q           <= lcr_d;
         mcr_q           <= mcr_d;
         scr_q           <= scr_d;
         dout_q          <= dout_d;
         rbr_last_q      <= rbr_last_d;
         rd_ack_q        <= rd_ack_d;
         wr_ack_q        <= wr_ack_d;
         oe_q            <= oe_d;
         fe_q            <= fe_d;
         thre_q          <= thre_d;
         tx_empty_prev_q <= tx_empty_prev_d;
         irq_q           <= irq_d;
         tx_state_q      <= tx_state_d;
         tx_cnt_q        <= tx_cnt_d;
         tx_bits_q       <= tx_bits_d;
         tx_shift_q      <= tx_shift_d;
         rx_state_q      <= rx_state_d;
         rx_cnt_q        <= rx_cnt_d;
         rx_bits_q       <= rx_bits_d;
         rx_shift_q      <= rx_shift_d;
         rx_sync_q       <= rx_sync_d;
      end
   end

   uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (rx_done),
      .pop     (rx_pop),
      .din     (rx_shift_d),
      .dout    (rx_head),
      .full    (rx_full),
      .empty   (rx_empty),
      .count   (rx_count)
   );

   uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (wr_thr),
      .pop     (tx_pop),
      .din     (din),
      .dout    (tx_head),
      .full    (tx_full),
      .empty   (tx_empty),
      .count   (tx_count)
   );

   assign dout        = dout_q;
   assign cpu_iordout = rd_ack_q;
   assign cpu_iowrout = wr_ack_q;
   assign ready       = (cpu_iordin == rd_ack_q) && (cpu_iowrin == wr_ack_q);
   assign irq         = irq_q;
   assign txd         = mcr_q[4] ? 1'b1 : tx_ser;

endmodule

// File: tb/tb_uart_port.sv
// Bench for uart_port: register table, handshake timing, TX waveform,
// loopback, RX overrun/framing, THRE interrupt and reset mid-frame.
module tb_uart_port;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [23:0] port = 24'h0003F8;
   logic [7:0]  din = 8'h00;
   logic [7:0]  dout;
   logic        iord = 1'b0, iowr = 1'b0;
   logic        iordout, iowrout, ready, irq, txd;
   logic        rxd = 1'b1;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] sb[$];

   typedef struct {
      logic       wr;
      logic [2:0] addr;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;
   vec_t vecs[$];

   always #5 clk = ~clk;

   uart_port #(.CLK_HZ(1_843_200), .REF_HZ(1_843_200), .FIFO_DEPTH(16)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .port        (port),
      .din         (din),
      .dout        (dout),
      .cpu_iordin  (iord),
      .cpu_iordout (iordout),
      .cpu_iowrin  (iowr),
      .cpu_iowrout (iowrout),
      .ready       (ready),
      .irq         (irq),
      .rxd         (rxd),
      .txd         (txd)
   );

   initial begin
      #400_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic io_write(input logic [2:0] a, input logic [7:0] d);
      int i;
      @(negedge clk);
      port = 24'h0003F8 | {21'h0, a};
      din  = d;
      iowr = ~iowr;
      i = 0;
      while (iowrout !== iowr && i < 20) begin
         @(negedge clk);
         i++;
      end
      if (iowrout !== iowr) begin
         n_tests++;
         n_fail++;
         $display("FAIL io_write timeout: ack %b req %b", iowrout, iowr);
      end
   endtask

   task automatic io_read(input logic [2:0] a, output logic [7:0] d);
      int i;
      @(negedge clk);
      port = 24'h0003F8 | {21'h0, a};
      iord = ~iord;
      i = 0;
      while (iordout !== iord && i < 20) begin
         @(negedge clk);
         i++;
      end
      if (iordout !== iord) begin
         n_tests++;
         n_fail++;
         $display("FAIL io_read timeout: ack %b req %b", iordout, iord);
      end
      d = dout;
   endtask

   task automatic read_check(input string name, input logic [2:0] a, input logic [7:0] exp);
      logic [7:0] v;
      io_read(a, v);
      check8(name, v, exp);
   endtask

   task automatic read_rbr_sb(input string name);
      logic [7:0] v;
      logic [7:0] e;
      io_read(3'd0, v);
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: got %02h with scoreboard empty", name, v);
      end else begin
         e = sb.pop_front();
         check8(name, v, e);
      end
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_ok);
      @(negedge clk);
      rxd = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (16) @(negedge clk);
      end
      rxd = stop_ok;
      repeat (stop_ok ? 16 : 12) @(negedge clk);
      rxd = 1'b1;
      repeat (16) @(negedge clk);
   endtask

   task automatic wait_txd_low(input string name);
      int i;
      i = 0;
      while (txd !== 1'b0 && i < 60) begin
         @(negedge clk);
         i++;
      end
      if (txd !== 1'b0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: txd never went low, txd=%b", name, txd);
      end
   endtask

   task automatic add_vec(input logic wr, input logic [2:0] a, input logic [7:0] d, input logic [7:0] e);
      vec_t v;
      v.wr = wr; v.addr = a; v.data = d; v.exp = e;
      vecs.push_back(v);
   endtask

   initial begin
      logic [7:0] v;
      logic [7:0] tx_byte;
      logic [7:0] last;
      logic       exp_oe;
      logic [7:0] exp_lsr;

      // Register table: after reset, ends with DLL=1, LCR=0x03, IER=0, MCR=0.
      add_vec(0, 3'd5, 8'h00, 8'h60);
      add_vec(0, 3'd2, 8'h00, 8'h01);
      add_vec(0, 3'd1, 8'h00, 8'h00);
      add_vec(0, 3'd6, 8'h00, 8'h00);
      add_vec(1, 3'd7, 8'hA5, 8'h00);
      add_vec(0, 3'd7, 8'h00, 8'hA5);
      add_vec(1, 3'd3, 8'h1B, 8'h00);
      add_vec(0, 3'd3, 8'h00, 8'h1B);
      add_vec(1, 3'd4, 8'hEF, 8'h00);
      add_vec(0, 3'd4, 8'h00, 8'h0F);
      add_vec(1, 3'd4, 8'h00, 8'h00);
      add_vec(1, 3'd3, 8'h80, 8'h00);
      add_vec(0, 3'd0, 8'h00, 8'h0C);
      add_vec(0, 3'd1, 8'h00, 8'h00);
      add_vec(1, 3'd0, 8'h01, 8'h00);
      add_vec(0, 3'd0, 8'h00, 8'h01);
      add_vec(1, 3'd3, 8'h03, 8'h00);
      add_vec(0, 3'd3, 8'h00, 8'h03);
      add_vec(0, 3'd0, 8'h00, 8'h00);
      add_vec(1, 3'd2, 8'hFF, 8'h00);
      add_vec(0, 3'd2, 8'h00, 8'h01);

      repeat (3) @(negedge clk);
      check8("reset dout", dout, 8'h00);
      check8("reset acks", {6'b0, iordout, iowrout}, 8'h00);
      check8("reset ready/irq/txd", {5'b0, ready, irq, txd}, 8'h05);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      foreach (vecs[i]) begin
         if (vecs[i].wr) begin
            io_write(vecs[i].addr, vecs[i].data);
         end else begin
            io_read(vecs[i].addr, v);
            check8($sformatf("vec%0d addr%0d", i, vecs[i].addr), v, vecs[i].exp);
         end
      end

      // Handshake: ack and dout one cycle after the toggle, ready low one cycle.
      @(negedge clk);
      port = 24'h0003FF;
      iord = ~iord;
      #1;
      check8("ready low during access", {7'b0, ready}, 8'h00);
      @(negedge clk);
      check8("ack after one cycle", {7'b0, iordout}, {7'b0, iord});
      check8("ready back high", {7'b0, ready}, 8'h01);
      check8("dout after one cycle", dout, 8'hA5);

      // TX waveform for 0x55 at one x16 tick per clock.
      tx_byte = 8'h55;
      io_write(3'd0, tx_byte);
      wait_txd_low("tx start");
      repeat (8) @(negedge clk);
      check8("tx start bit", {7'b0, txd}, 8'h00);
      for (int i = 0; i < 8; i++) begin
         repeat (16) @(negedge clk);
         check8($sformatf("tx bit%0d", i), {7'b0, txd}, {7'b0, tx_byte[i]});
      end
      repeat (16) @(negedge clk);
      check8("tx stop bit", {7'b0, txd}, 8'h01);
      repeat (12) @(negedge clk);
      read_check("lsr temt after stop", 3'd5, 8'h60);

      // Loopback: two bytes come back through the receiver.
      io_write(3'd4, 8'h10);
      io_write(3'd0, 8'hA5); sb.push_back(8'hA5);
      io_write(3'd0, 8'h3C); sb.push_back(8'h3C);
      repeat (50) @(negedge clk);
      check8("loopback txd forced high", {7'b0, txd}, 8'h01);
      repeat (350) @(negedge clk);
      read_rbr_sb("loopback rbr0");
      read_rbr_sb("loopback rbr1");
      io_read(3'd5, v);
      check8("loopback dr cleared", {7'b0, v[0]}, 8'h00);
      io_write(3'd4, 8'h00);
      repeat (20) @(negedge clk);

      // Overrun: 17 frames into a 16-entry FIFO.
      exp_oe = 1'b0;
      for (int i = 0; i < 17; i++) begin
         v = 8'($urandom_range(0, 255));
         if (sb.size() < 16) sb.push_back(v);
         else exp_oe = 1'b1;
         send_rx(v, 1'b1);
      end
      exp_lsr = 8'h60 | {6'b0, exp_oe, (sb.size() != 0)};
      read_check("lsr overrun", 3'd5, exp_lsr);
      for (int i = 0; i < 16; i++) begin
         last = sb[0];
         read_rbr_sb($sformatf("overrun rbr%0d", i));
      end
      read_check("rbr empty repeats last", 3'd0, last);
      read_check("lsr oe cleared", 3'd5, 8'h60);

      // Framing error on 0x81 and line status interrupt.
      sb.push_back(8'h81);
      send_rx(8'h81, 1'b0);
      read_rbr_sb("fe rbr");
      io_write(3'd1, 8'h04);
      repeat (3) @(negedge clk);
      check8("irq line status", {7'b0, irq}, 8'h01);
      read_check("iir line status", 3'd2, 8'h06);
      read_check("lsr fe", 3'd5, 8'h68);
      read_check("iir after lsr read", 3'd2, 8'h01);
      repeat (3) @(negedge clk);
      check8("irq cleared after lsr", {7'b0, irq}, 8'h00);

      // THRE interrupt armed by enabling IER1 with an empty TX FIFO.
      io_write(3'd1, 8'h02);
      repeat (3) @(negedge clk);
      check8("irq thre", {7'b0, irq}, 8'h01);
      read_check("iir thre", 3'd2, 8'h02);
      repeat (3) @(negedge clk);
      check8("irq thre cleared", {7'b0, irq}, 8'h00);
      read_check("iir none", 3'd2, 8'h01);
      io_write(3'd1, 8'h00);

      // Reset in the middle of a frame with a second byte still queued.
      io_write(3'd0, 8'hF0);
      io_write(3'd0, 8'h0F);
      wait_txd_low("reset tx start");
      repeat (20) @(negedge clk);
      reset_n = 1'b0;
      iord = 1'b0;
      iowr = 1'b0;
      #1;
      check8("txd high in reset", {7'b0, txd}, 8'h01);
      check8("ready/irq in reset", {6'b0, ready, irq}, 8'h02);
      check8("dout in reset", dout, 8'h00);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      read_check("lsr after reset", 3'd5, 8'h60);
      read_check("rbr after reset", 3'd0, 8'h00);
      repeat (40) @(negedge clk);
      check8("txd idle after reset", {7'b0, txd}, 8'h01);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
